// File: rtl/sync_toggle_rx_if.sv
// rtl/sync_toggle_rx_if.sv - toggle-handshake crossing bus: source request/data/ack plus consumer valid/ready
interface sync_toggle_rx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_sync;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  ack_toggle;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    // Source side and consumer side together, as seen from outside the receiver
    modport master (
        output req_sync,
        output src_data,
        output out_ready,
        input  ack_toggle,
        input  out_valid,
        input  out_data
    );

    // The receiver itself
    modport slave (
        input  req_sync,
        input  src_data,
        input  out_ready,
        output ack_toggle,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/sync_toggle_rx.sv
// rtl/sync_toggle_rx.sv - destination-side toggle-handshake receiver with capture, ack toggle and overrun stats
module sync_toggle_rx #(
    parameter int DATA_WIDTH    = 32,
    parameter int OVF_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    sync_toggle_rx_if.slave          bus,
    input  logic                     clr_stat_i,
    output logic                     ovf_o,
    output logic [OVF_CNT_WIDTH-1:0] ovf_cnt_o,
    output logic [15:0]              xfer_cnt_o
);
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   state_q;
    logic                     req_prev_q;
    logic                     primed_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic                     ack_q;
    logic                     ovf_q;
    logic                     ovf_d;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_d;
    logic [15:0]              xfer_cnt_q;

    logic req_edge;
    logic overrun;
    logic accept;

    // The first cycle after reset only learns the request level, so a
    // level left over from before reset is never mistaken for a request.
    assign req_edge = primed_q & (bus.req_sync ^ req_prev_q);
    assign overrun  = req_edge & (state_q == HOLD);
    assign accept   = (state_q == HOLD) & bus.out_ready;

    // Overrun statistics: clear first, then a same-cycle overrun counts on top of the cleared value
    always_comb begin
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (clr_stat_i) begin
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
        end
        if (overrun) begin
            ovf_d = 1'b1;
            if (ovf_cnt_d != '1) begin
                ovf_cnt_d = ovf_cnt_d + OVF_CNT_WIDTH'(1);
            end
        end
    end

    // Capture/hold FSM with edge tracking, ack toggle and counters
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            req_prev_q <= 1'b0;
            primed_q   <= 1'b0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_cnt_q  <= '0;
            xfer_cnt_q <= '0;
        end else begin
            req_prev_q <= bus.req_sync;
            primed_q   <= 1'b1;
            ovf_q      <= ovf_d;
            ovf_cnt_q  <= ovf_cnt_d;
            case (state_q)
                IDLE: begin
                    if (req_edge) begin
                        data_q  <= bus.src_data;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // An edge here is an overrun: data_q is left untouched
                    if (accept) begin
                        ack_q      <= ~ack_q;
                        xfer_cnt_q <= xfer_cnt_q + 16'd1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_data   = data_q;
    assign bus.ack_toggle = ack_q;
    assign ovf_o          = ovf_q;
    assign ovf_cnt_o      = ovf_cnt_q;
    assign xfer_cnt_o     = xfer_cnt_q;
endmodule

// File: tb/tb_sync_toggle_rx.sv
// tb/tb_sync_toggle_rx.sv - self-checking bench for sync_toggle_rx
module tb_sync_toggle_rx;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr_stat = 1'b0;
    logic        ovf;
    logic [7:0]  ovf_cnt;
    logic [15:0] xfer_cnt;
    logic        dir_ready = 1'b0;
    logic        rnd_ready = 1'b0;
    logic        stream_en = 1'b0;
    logic        chk_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    logic [DW-1:0] sb[$];

    sync_toggle_rx_if #(.DATA_WIDTH(DW)) bus ();

    assign bus.out_ready = stream_en ? rnd_ready : dir_ready;

    always #5 clk = ~clk;

    sync_toggle_rx #(.DATA_WIDTH(DW), .OVF_CNT_WIDTH(8)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .bus        (bus.slave),
        .clr_stat_i (clr_stat),
        .ovf_o      (ovf),
        .ovf_cnt_o  (ovf_cnt),
        .xfer_cnt_o (xfer_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is either pending for the consumer or not;
    // request toggles seen while one is pending are overruns.
    bit          m_primed = 1'b0;
    logic        m_prev = 1'b0;
    bit          m_pending = 1'b0;
    logic [DW-1:0] m_word = '0;
    logic        m_ack = 1'b0;
    bit          m_ovf = 1'b0;
    int          m_cnt = 0;
    int          m_xfer = 0;

    always @(posedge clk) begin : model
        bit toggle;
        if (reset) begin
            m_primed = 1'b0; m_prev = 1'b0; m_pending = 1'b0; m_word = '0;
            m_ack = 1'b0; m_ovf = 1'b0; m_cnt = 0; m_xfer = 0;
        end else begin
            toggle = m_primed && (bus.req_sync != m_prev);
            if (clr_stat) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
            if (m_pending) begin
                if (toggle) begin
                    m_ovf = 1'b1;
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                end
                if (bus.out_ready) begin
                    m_pending = 1'b0;
                    m_ack = ~m_ack;
                    m_xfer = (m_xfer + 1) % 65536;
                end
            end else if (toggle) begin
                m_pending = 1'b1;
                m_word = bus.src_data;
            end
            m_prev = bus.req_sync;
            m_primed = 1'b1;
        end
    end

    // Every-cycle comparison against the model, plus stream order scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 64'(bus.out_valid), 64'(m_pending));
            if (m_pending) check("data", 64'(bus.out_data), 64'(m_word));
            check("ack", 64'(bus.ack_toggle), 64'(m_ack));
            check("ovf", 64'(ovf), 64'(m_ovf));
            check("ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
            check("xfer_cnt", 64'(xfer_cnt), 64'(m_xfer));
            if (stream_en && bus.out_valid && bus.out_ready) begin
                check("sb_avail", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    check("sb_order", 64'(bus.out_data), 64'(sb.pop_front()));
                    n_acc++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int vcnt;
        int acnt;
        int first_ack;
        logic prev_ack;
        logic old_ack;
        logic [DW-1:0] w;
        bit got;
        int k;

        // Reset with req_sync high, then priming
        bus.req_sync = 1'b1;
        bus.src_data = '0;
        reset = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        reset = 1'b0;
        vcnt = 0;
        repeat (20) begin
            tick();
            if (bus.out_valid) vcnt++;
        end
        check("prime_no_valid", 64'(vcnt), 64'(0));
        check("prime_ack", 64'(bus.ack_toggle), 64'(0));
        check("prime_ovf", 64'(ovf), 64'(0));
        check("prime_xfer", 64'(xfer_cnt), 64'(0));

        // Single transfer with out_ready held high
        dir_ready = 1'b1;
        bus.src_data = 32'hDEADBEEF;
        bus.req_sync = ~bus.req_sync;
        tick();
        check("single_valid", 64'(bus.out_valid), 64'(1));
        check("single_data", 64'(bus.out_data), 64'h0000_0000_DEAD_BEEF);
        tick();
        check("single_valid_drop", 64'(bus.out_valid), 64'(0));
        check("single_ack", 64'(bus.ack_toggle), 64'(1));
        check("single_xfer", 64'(xfer_cnt), 64'(1));

        // Backpressure: ready low for 15 valid cycles, then high
        dir_ready = 1'b0;
        bus.src_data = 32'h12345678;
        bus.req_sync = ~bus.req_sync;
        vcnt = 0;
        acnt = 0;
        first_ack = 0;
        prev_ack = bus.ack_toggle;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (bus.out_valid) begin
                vcnt++;
                check("bp_data", 64'(bus.out_data), 64'h0000_0000_1234_5678);
            end
            if (bus.ack_toggle != prev_ack) begin
                acnt++;
                if (first_ack == 0) first_ack = i;
            end
            prev_ack = bus.ack_toggle;
            if (i == 16) dir_ready = 1'b1;
        end
        dir_ready = 1'b0;
        check("bp_valid_cycles", 64'(vcnt), 64'(16));
        check("bp_ack_flips", 64'(acnt), 64'(1));
        check("bp_ack_cycle", 64'(first_ack), 64'(17));
        check("bp_xfer", 64'(xfer_cnt), 64'(2));

        // Overrun, saturation, clear, and clear colliding with an overrun
        bus.src_data = 32'hAAAA5555;
        bus.req_sync = ~bus.req_sync;
        tick();
        check("ovr_valid", 64'(bus.out_valid), 64'(1));
        bus.src_data = 32'h0;
        bus.req_sync = ~bus.req_sync;
        tick();
        check("ovr_flag", 64'(ovf), 64'(1));
        check("ovr_cnt1", 64'(ovf_cnt), 64'(1));
        check("ovr_data_kept", 64'(bus.out_data), 64'h0000_0000_AAAA_5555);
        repeat (299) begin
            bus.req_sync = ~bus.req_sync;
            tick();
        end
        check("ovr_sat", 64'(ovf_cnt), 64'(255));
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        check("clr_ovf", 64'(ovf), 64'(0));
        check("clr_cnt", 64'(ovf_cnt), 64'(0));
        clr_stat = 1'b1;
        bus.req_sync = ~bus.req_sync;
        tick();
        clr_stat = 1'b0;
        check("clr_vs_ovr_flag", 64'(ovf), 64'(1));
        check("clr_vs_ovr_cnt", 64'(ovf_cnt), 64'(1));
        check("ovr_still_valid", 64'(bus.out_valid), 64'(1));
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        check("ovr_drained", 64'(bus.out_valid), 64'(0));
        check("ovr_xfer", 64'(xfer_cnt), 64'(3));

        // Reset while holding a word
        bus.src_data = 32'h0BADF00D;
        bus.req_sync = ~bus.req_sync;
        tick();
        check("rst_hold_valid", 64'(bus.out_valid), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_ack", 64'(bus.ack_toggle), 64'(0));
        check("rst_xfer", 64'(xfer_cnt), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        tick();
        bus.src_data = 32'h600DCAFE;
        bus.req_sync = ~bus.req_sync;
        tick();
        check("post_rst_valid", 64'(bus.out_valid), 64'(1));
        check("post_rst_data", 64'(bus.out_data), 64'h0000_0000_600D_CAFE);
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        check("post_rst_ack", 64'(bus.ack_toggle), 64'(1));

        // Streaming with a source that waits for ack and a random consumer
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        stream_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            w = $urandom;
            bus.src_data = w;
            sb.push_back(w);
            old_ack = bus.ack_toggle;
            bus.req_sync = ~bus.req_sync;
            got = 1'b0;
            k = 0;
            while (!got && k < 100) begin
                tick();
                if (bus.ack_toggle != old_ack) got = 1'b1;
                k++;
            end
            check("stream_ack_wait", 64'(got), 64'(1));
            if (!got) break;
            repeat ($urandom_range(0, 3)) tick();
        end
        stream_en = 1'b0;
        repeat (3) tick();
        check("stream_xfer", 64'(xfer_cnt), 64'(1000));
        check("stream_ovf", 64'(ovf), 64'(0));
        check("stream_accepted", 64'(n_acc), 64'(1000));
        check("stream_sb_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
